// File: rtl/pp_pkg.sv
// Shared definitions for the ping-pong arbiter: FSM state encoding and default
// burst-length counter width.
package pp_pkg;

   localparam int PP_LEN_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_BURST = 2'd2,
      ST_DONE  = 2'd3
   } pp_state_t;

endpackage

// File: rtl/pp_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins. On a tie, the
// requester that was not served last wins.
module pp_rr_pick (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic owner,
   output logic valid
);

   assign valid = req0 | req1;
   assign owner = (req0 & req1) ? ~ptr : req1;

endmodule

// File: rtl/pp_arb_ctrl.sv
// Arbitrates two requesters for a shared sequence FSM. The winner gets a reset
// pulse, a burst of registered x/y stimulus, and a latched q_in result.
module pp_arb_ctrl
   import pp_pkg::*;
#(
   parameter int LEN_W = PP_LEN_W
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             x0,
   input  logic             y0,
   input  logic             x1,
   input  logic             y1,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic             q_in,
   output logic             gnt0,
   output logic             gnt1,
   output logic             x_o,
   output logic             y_o,
   output logic             fsm_rst,
   output logic             done,
   output logic             aborted,
   output logic             result,
   output logic             busy
);

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   logic             w_owner;
   logic             w_valid;
   logic             w_own_req;
   logic             w_own_x;
   logic             w_own_y;
   logic [LEN_W-1:0] w_req_len;

   pp_state_t        r_state;
   logic             r_owner;
   logic             r_ptr;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic             r_gnt0;
   logic             r_gnt1;
   logic             r_x;
   logic             r_y;
   logic             r_fsm_rst;
   logic             r_done;
   logic             r_aborted;
   logic             r_result;
   logic             r_busy;

   pp_rr_pick u_pick (
      .req0  (req0),
      .req1  (req1),
      .ptr   (r_ptr),
      .owner (w_owner),
      .valid (w_valid)
   );

   // Once the block is busy only the latched owner's inputs are looked at.
   assign w_own_req = r_owner ? req1 : req0;
   assign w_own_x   = r_owner ? x1   : x0;
   assign w_own_y   = r_owner ? y1   : y0;
   assign w_req_len = w_owner ? len1 : len0;

   // NOTE: every state bit uses <= so all registers update from pre-edge values.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state   <= ST_IDLE;
         r_owner   <= 1'b0;
         r_ptr     <= 1'b1;
         r_len     <= '0;
         r_cnt     <= '0;
         r_gnt0    <= 1'b0;
         r_gnt1    <= 1'b0;
         r_x       <= 1'b0;
         r_y       <= 1'b0;
         r_fsm_rst <= 1'b1;
         r_done    <= 1'b0;
         r_aborted <= 1'b0;
         r_result  <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_fsm_rst <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_state   <= ST_SETUP;
                  r_owner   <= w_owner;
                  r_ptr     <= w_owner;
                  r_len     <= (w_req_len == '0) ? ONE : w_req_len;
                  r_gnt0    <= ~w_owner;
                  r_gnt1    <= w_owner;
                  r_fsm_rst <= 1'b1;
                  r_busy    <= 1'b1;
                  r_x       <= 1'b0;
                  r_y       <= 1'b0;
               end
            end
            ST_SETUP: begin
               r_state <= ST_BURST;
               r_cnt   <= r_len;
               r_x     <= w_own_x;
               r_y     <= w_own_y;
            end
            ST_BURST: begin
               r_cnt <= r_cnt - ONE;
               if (!w_own_req || r_cnt == ONE) begin
                  // A drop coinciding with the final count is a normal completion.
                  r_state   <= ST_DONE;
                  r_done    <= 1'b1;
                  r_result  <= q_in;
                  r_aborted <= (r_cnt != ONE);
                  r_gnt0    <= 1'b0;
                  r_gnt1    <= 1'b0;
                  r_x       <= 1'b0;
                  r_y       <= 1'b0;
               end else begin
                  r_x <= w_own_x;
                  r_y <= w_own_y;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt0    = r_gnt0;
   assign gnt1    = r_gnt1;
   assign x_o     = r_x;
   assign y_o     = r_y;
   assign fsm_rst = r_fsm_rst;
   assign done    = r_done;
   assign aborted = r_aborted;
   assign result  = r_result;
   assign busy    = r_busy;

endmodule

// File: tb/tb_pp_arb_ctrl.sv
// Self-checking bench for pp_arb_ctrl: directed scenarios followed by random
// transactions predicted by a transaction-level round-robin/burst model.
module tb_pp_arb_ctrl;

   localparam int LEN_W = 4;

   logic             Clk = 1'b0;
   logic             Rst = 1'b1;
   logic             req0 = 1'b0, req1 = 1'b0;
   logic             x0 = 1'b0, y0 = 1'b0, x1 = 1'b0, y1 = 1'b0;
   logic [LEN_W-1:0] len0 = '0, len1 = '0;
   logic             q_in = 1'b0;
   logic             gnt0, gnt1, x_o, y_o, fsm_rst, done, aborted, result, busy;

   int checks   = 0;
   int failures = 0;

   // Model state: who was served last, and the held end-of-burst flags.
   bit last_owner  = 1'b1;
   bit exp_aborted = 1'b0;
   bit exp_result  = 1'b0;

   pp_arb_ctrl #(.LEN_W(LEN_W)) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .req0    (req0),
      .req1    (req1),
      .x0      (x0),
      .y0      (y0),
      .x1      (x1),
      .y1      (y1),
      .len0    (len0),
      .len1    (len1),
      .q_in    (q_in),
      .gnt0    (gnt0),
      .gnt1    (gnt1),
      .x_o     (x_o),
      .y_o     (y_o),
      .fsm_rst (fsm_rst),
      .done    (done),
      .aborted (aborted),
      .result  (result),
      .busy    (busy)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit g0, input bit g1, input bit xo,
                             input bit yo, input bit fr, input bit dn, input bit bz);
      check({tag, ".gnt0"},    gnt0,    g0);
      check({tag, ".gnt1"},    gnt1,    g1);
      check({tag, ".x_o"},     x_o,     xo);
      check({tag, ".y_o"},     y_o,     yo);
      check({tag, ".fsm_rst"}, fsm_rst, fr);
      check({tag, ".done"},    done,    dn);
      check({tag, ".busy"},    busy,    bz);
      check({tag, ".aborted"}, aborted, exp_aborted);
      check({tag, ".result"},  result,  exp_result);
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_xy(input bit rnd);
      if (rnd) begin
         x0 = 1'($urandom);
         y0 = 1'($urandom);
         x1 = 1'($urandom);
         y1 = 1'($urandom);
      end else begin
         x0 = 1'b1;
         y0 = 1'b0;
         x1 = 1'b0;
         y1 = 1'b1;
      end
      q_in = 1'($urandom);
   endtask

   // Inputs for one busy cycle: owner req as given, everything else scrambled.
   task automatic drive_busy(input bit own, input bit own_req, input bit rnd,
                             output bit sx, output bit sy);
      if (own) begin
         req1 = own_req;
         req0 = 1'($urandom);
      end else begin
         req0 = own_req;
         req1 = 1'($urandom);
      end
      len0 = LEN_W'($urandom);
      len1 = LEN_W'($urandom);
      set_xy(rnd);
      sx = own ? x1 : x0;
      sy = own ? y1 : y0;
   endtask

   task automatic apply_reset(input int cycles);
      Rst  = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      exp_aborted = 1'b0;
      exp_result  = 1'b0;
      #1;
      check_outs("rst_assert", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (cycles) @(posedge Clk);
      #1;
      check_outs("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      Rst = 1'b1;
      last_owner = 1'b1;
      step();
      check_outs("rst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req0 = 1'b0;
         req1 = 1'b0;
         set_xy(1'b1);
         step();
         check_outs("idle_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // One whole transaction from IDLE back to IDLE. hold_in >= 0 means the
   // owner keeps req high for that many BURST cycles and then drops it.
   task automatic do_txn(input bit r0, input bit r1, input int l0, input int l1,
                         input int hold_in, input bit rnd);
      bit own, sx, sy, qv;
      int eff, hold, nb;
      own = (r0 && r1) ? !last_owner : r1;
      eff = own ? l1 : l0;
      if (eff == 0) eff = 1;
      hold = hold_in;
      if (hold >= 0 && hold + 1 >= eff) hold = -1;
      nb = (hold >= 0) ? hold + 1 : eff;

      req0 = r0;
      req1 = r1;
      len0 = LEN_W'(l0);
      len1 = LEN_W'(l1);
      set_xy(rnd);
      step();
      check_outs("setup", !own, own, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      last_owner = own;

      drive_busy(own, 1'b1, rnd, sx, sy);
      step();
      check_outs("burst_first", !own, own, sx, sy, 1'b0, 1'b0, 1'b1);

      for (int k = 1; k <= nb; k++) begin
         drive_busy(own, (hold < 0) || (k <= hold), rnd, sx, sy);
         qv = q_in;
         step();
         if (k < nb) begin
            check_outs("burst", !own, own, sx, sy, 1'b0, 1'b0, 1'b1);
         end else begin
            exp_result  = qv;
            exp_aborted = (hold >= 0);
            check_outs("done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         end
      end

      drive_busy(own, 1'($urandom), rnd, sx, sy);
      step();
      check_outs("back_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      bit r0, r1;
      int hold;

      #2;
      apply_reset(2);

      // Single requester, len 3, fixed x0=1 y0=0.
      do_txn(1'b1, 1'b0, 3, 0, -1, 1'b0);

      // Both requesting from reset: 0, then 1, then 0.
      apply_reset(2);
      do_txn(1'b1, 1'b1, 2, 2, -1, 1'b1);
      check("rr_first_owner0", last_owner, 1'b0);
      do_txn(1'b1, 1'b1, 2, 2, -1, 1'b1);
      check("rr_second_owner1", last_owner, 1'b1);
      do_txn(1'b1, 1'b1, 2, 2, -1, 1'b1);

      // req1 len 5 dropped after 2 BURST cycles -> aborted.
      do_txn(1'b0, 1'b1, 0, 5, 2, 1'b1);
      check("abort_flag_model", exp_aborted, 1'b1);
      idle(2);

      // len 0 behaves as len 1.
      do_txn(1'b1, 1'b0, 0, 0, -1, 1'b1);

      // Reset in mid-burst after req0 was served: no done, pointer back to 1.
      do_txn(1'b1, 1'b0, 2, 0, -1, 1'b1);
      req0 = 1'b1;
      req1 = 1'b0;
      len0 = LEN_W'(6);
      step();
      check("midrst.setup_gnt0", gnt0, 1'b1);
      step();
      step();
      check("midrst.burst_gnt0", gnt0, 1'b1);
      Rst = 1'b0;
      exp_aborted = 1'b0;
      exp_result  = 1'b0;
      #1;
      check_outs("midrst_assert", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      step();
      check_outs("midrst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      req0 = 1'b0;
      Rst  = 1'b1;
      last_owner = 1'b1;
      step();
      check_outs("midrst_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      do_txn(1'b1, 1'b1, 2, 2, -1, 1'b1);
      check("midrst_tie_owner0", last_owner, 1'b0);

      // Random transactions.
      for (int t = 0; t < 40; t++) begin
         r0 = 1'($urandom);
         r1 = 1'($urandom);
         if (!r0 && !r1) r1 = 1'b1;
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
         do_txn(r0, r1, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), hold, 1'b1);
         idle(int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pp_arb_ctrl.md
PP_ARB_CTRL -- requirements
Module: pp_arb_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 4, meaning burst-length counter width.
REQ-002 SHALL have port Clk  input  1  single system clock, rising edge.
REQ-003 SHALL have port Rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req0/req1  input  1 each  requester holds high to request or keep the shared FSM.
REQ-005 SHALL have ports x0,y0/x1,y1  input  1 each  requester stimulus for the shared FSM.
REQ-006 SHALL have ports len0/len1  input  LEN_W each  requested burst length in cycles, with 0 treated as 1.
REQ-007 SHALL have port q_in  input  1  output of the shared sequence FSM.
REQ-008 SHALL have ports gnt0/gnt1  output  1 each  one-hot-or-zero ownership grant.
REQ-009 SHALL have ports x_o,y_o  output  1 each  registered stimulus to the shared FSM.
REQ-010 SHALL have port fsm_rst  output  1  active-high reset pulse to the shared FSM.
REQ-011 SHALL have ports done, aborted, result  output  1 each  end-of-burst pulse, early-termination flag, and latched q_in.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement states IDLE, SETUP, BURST and DONE.
REQ-014 IDLE->SETUP SHALL occur on the first edge with req0|req1, latching owner, len (0->1), and asserting gnt<owner>=1 and fsm_rst=1 for that one cycle, with x_o=y_o=0.
REQ-015 SETUP->BURST SHALL be unconditional; the down-counter loads len.
REQ-016 In BURST, each edge SHALL register x_o<=x<owner> and y_o<=y<owner> and decrement the counter, so exactly len BURST cycles occur.
REQ-017 BURST->DONE SHALL occur on the edge after the counter reaches 1, or on the first edge the owner's req is sampled low.
REQ-018 On DONE entry: done=1 for exactly one cycle, result<=q_in, aborted=1 only if caused by req drop, gnts=0, x_o=y_o=0.
REQ-019 DONE->IDLE SHALL be unconditional; a pending request therefore waits at least one IDLE cycle.
REQ-020 Arbitration SHALL be round-robin: a 1-bit last-owner pointer is updated at SETUP, and on simultaneous requests the requester not last served wins.
REQ-021 A single requester SHALL always win regardless of pointer.
REQ-022 The non-owner's req, x, y and len SHALL be ignored while the block is busy.
REQ-023 gnt0 and gnt1 SHALL never both be high.
REQ-024 result and aborted SHALL hold their values until the next DONE.
REQ-025 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-026 Latency: req sampled at edge E1 -> gnt at E1, BURST from E2, done at E(len+2).

Reset
REQ-027 Rst low SHALL immediately force IDLE, gnt0=gnt1=0, x_o=y_o=0, fsm_rst=1, done=aborted=result=0, busy=0, counter=0, and pointer=1 (so req0 wins first tie).
REQ-028 fsm_rst SHALL deassert on the first edge after Rst rises.
REQ-029 Reset asserted mid-BURST SHALL discard the burst without a done pulse.

Structure
REQ-030 State encodings and the LEN_W default SHALL live in shared package pp_pkg.
REQ-031 The round-robin pick logic SHALL be sub-module pp_rr_pick (inputs req0, req1, ptr; outputs owner, valid), with the FSM and counter in pp_arb_ctrl.

Verification
REQ-032 Rst low for 2 cycles, then release -> all outputs 0 except fsm_rst=1 during reset; fsm_rst=0 one edge after release.
REQ-033 req0=1, len0=3, x0=1, y0=0 -> gnt0 for 4 cycles, fsm_rst for 1, x_o=1 for 3 cycles, done pulse, aborted=0, result=q_in at DONE.
REQ-034 req0 and req1 both high from reset, each len=2 -> req0 served first, then req1 after one IDLE cycle, then req0 again.
REQ-035 req1 burst with len1=5, req1 dropped after 2 BURST cycles -> DONE next edge, aborted=1, gnt1 low.
REQ-036 len0=0 -> exactly 1 BURST cycle, done at E2 relative to grant.
REQ-037 Rst pulled low mid-BURST -> immediate IDLE, no done pulse, and the next grant goes to req0 on a tie.
